// File: rtl/cnn_maxpool.sv
// cnn_maxpool: 2x2 stride-2 signed max pooling over a raster-ordered CO-channel feature map.
// Latency: one cycle from the odd-row, odd-column input beat to o_valid.
// Backpressure: none; a pixel is accepted on every i_valid beat, and idle cycles are harmless.
//
// Ports:
//   clk, reset         - single clock; asynchronous active-high reset
//   i_valid, i_fmap    - one input pixel per beat; channel c in [c*I_F_BW +: I_F_BW], signed
//   o_valid, o_fmap    - one pooled pixel per 2x2 window, with the same packing; o_fmap holds between outputs
//   o_last             - marks the final pooled pixel of a frame
// IW must be even and at least 4, and IH must be even.
module cnn_maxpool #(
    parameter int CO     = 3,
    parameter int I_F_BW = 20,
    parameter int IW     = 24,
    parameter int IH     = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    input  logic [CO*I_F_BW-1:0] i_fmap,
    output logic                 o_valid,
    output logic [CO*I_F_BW-1:0] o_fmap,
    output logic                 o_last
);

    localparam int CW = $clog2(IW);
    localparam int RW = (IH > 2) ? $clog2(IH) : 1;
    localparam int LW = CW - 1;          // line-buffer index width, equal to col >> 1
    localparam int FW = CO * I_F_BW;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [FW-1:0] hold_q, hold_d;
    logic [FW-1:0] o_fmap_q, o_fmap_d;
    logic          o_valid_q, o_valid_d;
    logic          o_last_q, o_last_d;

    // The pair maxima from the most recent even row, one entry per horizontal pair
    logic [FW-1:0] lb_q [IW/2];

    logic [FW-1:0] pair_max;
    logic [FW-1:0] pool_max;
    logic [LW-1:0] lb_idx;
    logic          col_odd, row_odd, col_last, row_last;

    function automatic logic [I_F_BW-1:0] smax(input logic [I_F_BW-1:0] a,
                                               input logic [I_F_BW-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    assign lb_idx   = col_q[CW-1:1];
    assign col_odd  = col_q[0];
    assign row_odd  = row_q[0];
    assign col_last = (col_q == CW'(IW - 1));
    assign row_last = (row_q == RW'(IH - 1));

    always_comb begin
        pair_max = '0;
        pool_max = '0;
        for (int c = 0; c < CO; c++) begin
            pair_max[c*I_F_BW +: I_F_BW] = smax(hold_q[c*I_F_BW +: I_F_BW],
                                                i_fmap[c*I_F_BW +: I_F_BW]);
            pool_max[c*I_F_BW +: I_F_BW] = smax(lb_q[lb_idx][c*I_F_BW +: I_F_BW],
                                                pair_max[c*I_F_BW +: I_F_BW]);
        end
    end

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        hold_d    = hold_q;
        o_fmap_d  = o_fmap_q;
        o_valid_d = 1'b0;
        o_last_d  = 1'b0;
        if (i_valid) begin
            if (!col_odd) begin
                hold_d = i_fmap;
            end
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            // The bottom-right pixel of a window completes it
            if (col_odd && row_odd) begin
                o_fmap_d  = pool_max;
                o_valid_d = 1'b1;
                o_last_d  = row_last && col_last;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q     <= '0;
            row_q     <= '0;
            hold_q    <= '0;
            o_fmap_q  <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            hold_q    <= hold_d;
            o_fmap_q  <= o_fmap_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
        end
    end

    // The line buffer is never read before the even row of the same frame writes it,
    // so it needs no reset. It is gated by reset so that a beat during reset leaves it untouched.
    always_ff @(posedge clk) begin
        if (!reset && i_valid && col_odd && !row_odd) begin
            lb_q[lb_idx] <= pair_max;
        end
    end

    assign o_valid = o_valid_q;
    assign o_fmap  = o_fmap_q;
    assign o_last  = o_last_q;

endmodule

// File: tb/tb_cnn_maxpool.sv
// tb_cnn_maxpool: directed frames for cnn_maxpool with a queue-based scoreboard.
// Latency: the expected output is stamped with the cycle in which it must appear.
// Backpressure: none; the monitor pops one entry per o_valid.
module tb_cnn_maxpool;

    localparam int CO = 3;
    localparam int W  = 20;
    localparam int IW = 24;
    localparam int IH = 24;
    localparam int FW = CO * W;

    localparam logic [W-1:0] NEG1   = 20'hFFFFF;
    localparam logic [W-1:0] NEG3   = 20'hFFFFD;
    localparam logic [W-1:0] NEG5   = 20'hFFFFB;
    localparam logic [W-1:0] MOST_N = 20'h80000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_valid = 1'b0;
    logic [FW-1:0] i_fmap = '0;
    logic          o_valid;
    logic [FW-1:0] o_fmap;
    logic          o_last;

    cnn_maxpool #(.CO(CO), .I_F_BW(W), .IW(IW), .IH(IH)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .i_fmap  (i_fmap),
        .o_valid (o_valid),
        .o_fmap  (o_fmap),
        .o_last  (o_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] dat;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    int            n_out = 0;
    logic [FW-1:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output is compared against the oldest expected entry
    always @(negedge clk) begin
        if (reset) begin
            held = '0;
        end else if (o_valid) begin
            n_out++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h with no expected entry (cycle %0d)", o_fmap, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("o_fmap", 64'(o_fmap), 64'(mon_e.dat));
                check("o_last", 64'(o_last), 64'(mon_e.last));
                check("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
            held = o_fmap;
        end else begin
            check("o_fmap_hold", 64'(o_fmap), 64'(held));
            check("o_last_idle", 64'(o_last), 64'd0);
        end
    end

    // Drive one beat on the next falling edge, then idle for `gap` cycles
    task automatic send(input logic [FW-1:0] px, input bit has_exp,
                        input logic [FW-1:0] ed, input bit el, input int gap);
        exp_t e;
        @(negedge clk);
        i_valid = 1'b1;
        i_fmap  = px;
        if (has_exp) begin
            e.dat  = ed;
            e.last = el;
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
        repeat (gap) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    // All channels carry row*24+col; the window maximum is its bottom-right pixel
    task automatic ramp_frame(input int gap, input int nbeats);
        logic [W-1:0]  v;
        logic [FW-1:0] px;
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                if (r * IW + c < nbeats) begin
                    v  = W'(r * IW + c);
                    px = {v, v, v};
                    send(px, (r % 2 == 1) && (c % 2 == 1), px,
                         (r == IH - 1) && (c == IW - 1), gap);
                end
            end
        end
    endtask

    // ch0: -5, with -1 at (odd row, even col) and the most negative value at (0,1); ch1 and ch2 are 0
    task automatic signed_frame();
        logic [W-1:0] v;
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                if ((r % 2 == 1) && (c % 2 == 0)) v = NEG1;
                else if (r == 0 && c == 1)        v = MOST_N;
                else                              v = NEG5;
                send({20'd0, 20'd0, v}, (r % 2 == 1) && (c % 2 == 1),
                     {20'd0, 20'd0, NEG1}, (r == IH - 1) && (c == IW - 1), 0);
            end
        end
    endtask

    // ch0 peaks top-left (9 over -3), ch1 peaks bottom-right (50 over 2), ch2 is constant 7
    task automatic chan_frame();
        logic [W-1:0] a, b;
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                a = ((r % 2 == 0) && (c % 2 == 0)) ? 20'd9 : NEG3;
                b = ((r % 2 == 1) && (c % 2 == 1)) ? 20'd50 : 20'd2;
                send({20'd7, b, a}, (r % 2 == 1) && (c % 2 == 1),
                     {20'd7, 20'd50, 20'd9}, (r == IH - 1) && (c == IW - 1), 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_o_valid", 64'(o_valid), 64'd0);
        check("reset_o_last", 64'(o_last), 64'd0);
        check("reset_o_fmap", 64'(o_fmap), 64'd0);

        // A beat presented while reset is high must not advance the counters
        @(negedge clk);
        i_valid = 1'b1;
        i_fmap  = {3{20'h12345}};
        @(negedge clk);
        reset   = 1'b0;
        i_valid = 1'b0;

        // Two ramp frames back to back, then the signed and channel patterns
        ramp_frame(0, IW * IH);
        ramp_frame(0, IW * IH);
        signed_frame();
        chan_frame();
        @(negedge clk);
        i_valid = 1'b0;

        // Ramp with a beat on every third cycle
        ramp_frame(2, IW * IH);

        // Abort a frame after 100 beats, with a stray beat held during reset
        ramp_frame(0, 100);
        @(negedge clk);
        i_valid = 1'b1;
        i_fmap  = {3{20'h7FFFF}};
        reset   = 1'b1;
        #1;
        check("midreset_o_valid", 64'(o_valid), 64'd0);
        check("midreset_o_fmap", 64'(o_fmap), 64'd0);
        check("midreset_o_last", 64'(o_last), 64'd0);
        @(negedge clk);
        reset   = 1'b0;
        i_valid = 1'b0;
        ramp_frame(0, IW * IH);
        @(negedge clk);
        i_valid = 1'b0;

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        // 2 + 1 + 1 + 1 full frames of 144, plus 24 from the aborted frame, plus the final 144
        check("output_count", 64'(n_out), 64'd888);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
